// File: rtl/spi_stream_pkg.sv
// spi_stream_pkg -- shared definitions for the SPI audio stream transmitter.
//   state_t      : transmit FSM states (IDLE -> LOAD -> SHIFT -> DONE)
//   ch_width()   : channel-tag width, max(1, clog2(num_ch))
//   frame_width(): serial frame length {present, chan, data}
package spi_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int frame_width(input int data_w, input int num_ch);
    return 1 + ch_width(num_ch) + data_w;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo -- synchronous FIFO with wrap-around pointers (extra MSB
// distinguishes full from empty).
//   clk, reset_n          : clock, async active-low reset (empties the FIFO)
//   push, push_data       : write strobe and data; ignored when full
//   pop, pop_data         : read strobe; pop_data shows the head (first-word fall-through)
//   full, empty, level    : status; level = occupied entries
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // NOTE: storage has no reset; emptiness is defined by the pointers alone,
  // so clearing the array would only cost reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/spi_stream_tx.sv
// spi_stream_tx -- buffers tagged PCM samples and serialises one per SPI
// frame to an MCU acting as SPI master (CPOL 0, CPHA selectable).
//   clk, reset_n        : system clock (>= 8x sck), async active-low reset
//   sck, cs_n           : SPI clock / chip select from MCU (asynchronous)
//   sdo                 : serial data to MCU, 0 outside an active frame
//   sample_valid/ready  : producer handshake; sample_data + sample_chan pushed
//   fifo_level          : occupied FIFO entries
//   underrun            : one-cycle pulse when a frame starts with FIFO empty
//   led                 : sticky underrun indicator, cleared only by reset
// Frame, MSB first: {present, chan, data}; all zeros on underrun.
module spi_stream_tx
  import spi_stream_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CH     = 2,
  parameter int CPHA       = 0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               sck,
  input  logic                               cs_n,
  output logic                               sdo,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  input  logic [DATA_W-1:0]                  sample_data,
  input  logic [ch_width(NUM_CH)-1:0]        sample_chan,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               underrun,
  output logic                               led
);

  localparam int CH_W    = ch_width(NUM_CH);
  localparam int FRAME_W = frame_width(DATA_W, NUM_CH);
  localparam int ENTRY_W = CH_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  // Two synchroniser stages plus one history stage for edge detection.
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] cs_sync_q,  cs_sync_d;
  logic       sck_rise, sck_fall, cs_fall, cs_rise;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 sdo_q,   sdo_d;
  logic                 underrun_q, underrun_d;
  logic                 led_q,   led_d;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;

  sample_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (sample_valid),
    .push_data ({sample_chan, sample_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign sample_ready = !fifo_full;
  assign underrun     = underrun_q;
  assign led          = led_q;

  assign sck_rise =  sck_sync_q[1] && !sck_sync_q[2];
  assign sck_fall = !sck_sync_q[1] &&  sck_sync_q[2];
  assign cs_fall  = !cs_sync_q[1]  &&  cs_sync_q[2];
  assign cs_rise  =  cs_sync_q[1]  && !cs_sync_q[2];

  // CPHA=0 drives straight from the shift register (MSB ready before the
  // first rising edge); CPHA=1 drives a bit registered on each rising edge.
  assign sdo = (state_q == ST_SHIFT) && ((CPHA != 0) ? sdo_q : shift_q[FRAME_W-1]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    sck_sync_d = {sck_sync_q[1:0], sck};
    cs_sync_d  = {cs_sync_q[1:0],  cs_n};
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    sdo_d      = sdo_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        fifo_pop   = !fifo_empty;
        underrun_d = fifo_empty;
        shift_d    = fifo_empty ? '0 : {1'b1, fifo_head};
        cnt_d      = '0;
        sdo_d      = 1'b0;
        // An abort here still consumes the popped sample.
        state_d    = cs_rise ? ST_IDLE : ST_SHIFT;
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (CPHA == 0) begin
          if (sck_fall) begin
            shift_d = shift_q << 1;
            if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = ST_DONE;
            else                              cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          if (sck_rise && cnt_q != CNT_W'(FRAME_W)) begin
            sdo_d   = shift_q[FRAME_W-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
          end else if (sck_fall && cnt_q == CNT_W'(FRAME_W)) begin
            // Last bit stays on sdo until the master has sampled it.
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (cs_rise) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    led_d = led_q || underrun_d;
  end

  // NOTE: state flops use non-blocking assignment so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q <= 3'b000;
      cs_sync_q  <= 3'b111;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      sdo_q      <= 1'b0;
      underrun_q <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      cs_sync_q  <= cs_sync_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      sdo_q      <= sdo_d;
      underrun_q <= underrun_d;
      led_q      <= led_d;
    end
  end

endmodule

// File: tb/tb_spi_stream_tx.sv
// tb_spi_stream_tx -- drives two instances from a shared SPI master model:
// u_dut0 default (CPHA0, 16-bit, 2 ch) and u_dut1 (CPHA1, 24-bit, 4 ch).
// The master samples dut0 before each rising sck edge and dut1 before each
// falling edge. A per-instance queue model predicts frames and status.
module tb_spi_stream_tx;

  localparam int HALF = 8;   // sck half period in clk cycles
  localparam int FW0  = 18;
  localparam int FW1  = 27;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n, sck, cs_n;
  logic        v0, v1, rdy0, rdy1, sdo0, sdo1, ur_o0, ur_o1, led0, led1;
  logic [15:0] d0;
  logic [23:0] d1;
  logic [0:0]  c0;
  logic [1:0]  c1;
  logic [3:0]  lvl0, lvl1;

  int tests_run = 0;
  int failures  = 0;
  int ur_cnt0, ur_cnt1;
  logic [63:0] rx0, rx1;
  logic [31:0] q0[$], q1[$];
  logic led_m0, led_m1;

  always #5 clk = ~clk;

  spi_stream_tx u_dut0 (
    .clk(clk), .reset_n(reset_n), .sck(sck), .cs_n(cs_n), .sdo(sdo0),
    .sample_valid(v0), .sample_ready(rdy0), .sample_data(d0), .sample_chan(c0),
    .fifo_level(lvl0), .underrun(ur_o0), .led(led0)
  );

  spi_stream_tx #(.DATA_W(24), .FIFO_DEPTH(8), .NUM_CH(4), .CPHA(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .sck(sck), .cs_n(cs_n), .sdo(sdo1),
    .sample_valid(v1), .sample_ready(rdy1), .sample_data(d1), .sample_chan(c1),
    .fifo_level(lvl1), .underrun(ur_o1), .led(led1)
  );

  always @(posedge clk) begin
    if (ur_o0 === 1'b1) ur_cnt0++;
    if (ur_o1 === 1'b1) ur_cnt1++;
  end

  // Expected master read of n bits: frame MSB first, zeros past its end.
  function automatic logic [63:0] exp_bits(input logic [31:0] fr, input int fw, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[62:0], (i < fw) ? fr[fw-1-i] : 1'b0};
    return r;
  endfunction

  task automatic push(input int which, input logic [23:0] data, input logic [1:0] chan);
    logic acc, exp_acc;
    @(negedge clk);
    if (which == 0) begin
      exp_acc = (q0.size() < DEPTH);
      v0 = 1'b1; d0 = data[15:0]; c0 = chan[0]; acc = rdy0;
    end else begin
      exp_acc = (q1.size() < DEPTH);
      v1 = 1'b1; d1 = data; c1 = chan; acc = rdy1;
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    tests_run++;
    if (acc !== exp_acc) begin
      failures++;
      $display("FAIL push_ready dut%0d got %b exp %b", which, acc, exp_acc);
    end
    if (acc === 1'b1) begin
      if (which == 0) q0.push_back({14'd0, 1'b1, chan[0], data[15:0]});
      else            q1.push_back({5'd0, 1'b1, chan, data});
    end
  endtask

  task automatic sck_bits(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (HALF) @(negedge clk);
      rx0 = {rx0[62:0], sdo0};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      rx1 = {rx1[62:0], sdo1};
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int nbits);
    @(negedge clk);
    rx0 = '0; rx1 = '0; ur_cnt0 = 0; ur_cnt1 = 0;
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    sck_bits(nbits);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic frame_and_check(input string name, input int nbits);
    logic [31:0] f0, f1;
    logic [63:0] e0, e1;
    int eu0, eu1;
    if (q0.size() > 0) begin f0 = q0.pop_front(); eu0 = 0; end
    else begin f0 = '0; eu0 = 1; led_m0 = 1'b1; end
    if (q1.size() > 0) begin f1 = q1.pop_front(); eu1 = 0; end
    else begin f1 = '0; eu1 = 1; led_m1 = 1'b1; end
    e0 = exp_bits(f0, FW0, nbits);
    e1 = exp_bits(f1, FW1, nbits);
    run_frame(nbits);
    tests_run += 8;
    if (rx0 !== e0) begin failures++; $display("FAIL %s rx0 got %h exp %h", name, rx0, e0); end
    if (rx1 !== e1) begin failures++; $display("FAIL %s rx1 got %h exp %h", name, rx1, e1); end
    if (ur_cnt0 != eu0) begin failures++; $display("FAIL %s underrun0 got %0d exp %0d", name, ur_cnt0, eu0); end
    if (ur_cnt1 != eu1) begin failures++; $display("FAIL %s underrun1 got %0d exp %0d", name, ur_cnt1, eu1); end
    if (int'(lvl0) != q0.size()) begin failures++; $display("FAIL %s level0 got %0d exp %0d", name, lvl0, q0.size()); end
    if (int'(lvl1) != q1.size()) begin failures++; $display("FAIL %s level1 got %0d exp %0d", name, lvl1, q1.size()); end
    if (led0 !== led_m0) begin failures++; $display("FAIL %s led0 got %b exp %b", name, led0, led_m0); end
    if (led1 !== led_m1) begin failures++; $display("FAIL %s led1 got %b exp %b", name, led1, led_m1); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sck = 1'b0; cs_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; c0 = '0; c1 = '0;
    led_m0 = 1'b0; led_m1 = 1'b0;
    repeat (3) @(negedge clk);
    tests_run += 4;
    if ({lvl0, lvl1} !== 8'h00) begin failures++; $display("FAIL reset_level got %h exp 00", {lvl0, lvl1}); end
    if ({sdo0, sdo1} !== 2'b00) begin failures++; $display("FAIL reset_sdo got %b exp 00", {sdo0, sdo1}); end
    if ({ur_o0, ur_o1} !== 2'b00) begin failures++; $display("FAIL reset_underrun got %b exp 00", {ur_o0, ur_o1}); end
    if ({led0, led1} !== 2'b00) begin failures++; $display("FAIL reset_led got %b exp 00", {led0, led1}); end
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({rdy0, rdy1} !== 2'b11) begin failures++; $display("FAIL reset_ready got %b exp 11", {rdy0, rdy1}); end
  endtask

  task automatic test_known_frame();
    push(0, 24'h001010, 2'd1);
    push(1, 24'hABCDEF, 2'd3);
    frame_and_check("known_frame", FW1);
    tests_run += 2;
    if (rx0[26:0] !== {18'b11_0001000000010000, 9'd0}) begin
      failures++; $display("FAIL known_cpha0 got %b", rx0[26:0]);
    end
    if (rx1[26:0] !== {1'b1, 2'b11, 24'hABCDEF}) begin
      failures++; $display("FAIL known_cpha1 got %h exp %h", rx1[26:0], {1'b1, 2'b11, 24'hABCDEF});
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) push(0, 24'($urandom), 2'($urandom));
    tests_run += 2;
    if (lvl0 !== 4'd8) begin failures++; $display("FAIL overflow_level got %0d exp 8", lvl0); end
    if (rdy0 !== 1'b0) begin failures++; $display("FAIL overflow_ready got %b exp 0", rdy0); end
    frame_and_check("overflow_pop", FW1);
    push(0, 24'($urandom), 2'($urandom));
    tests_run++;
    if (lvl0 !== 4'd8) begin failures++; $display("FAIL overflow_refill got %0d exp 8", lvl0); end
    while (q0.size() > 0 || q1.size() > 0) frame_and_check("overflow_drain", FW1);
  endtask

  task automatic test_underrun();
    frame_and_check("underrun_empty", FW1 + 3);
    push(0, 24'($urandom), 2'($urandom));
    push(1, 24'($urandom), 2'($urandom));
    frame_and_check("underrun_led_sticky", FW1);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 2; i++) begin
      push(0, 24'($urandom), 2'($urandom));
      push(1, 24'($urandom), 2'($urandom));
    end
    frame_and_check("abort_5bits", 5);
    frame_and_check("abort_next", FW1);
  endtask

  // A push landing near frame start must be sent exactly once, whichever
  // of the two frames it reaches, and exactly one of them underruns.
  task automatic test_push_at_frame_start();
    logic [63:0] a_rx, b_rx, e_full;
    int a_ur, b_ur;
    logic [15:0] val;
    logic ch;
    for (int k = 1; k <= 6; k++) begin
      val = 16'($urandom) | 16'h0001;
      ch  = 1'($urandom);
      e_full = exp_bits({14'd0, 1'b1, ch, val}, FW0, FW1);
      fork
        run_frame(FW1);
        begin
          repeat (k) @(negedge clk);
          v0 = 1'b1; d0 = val; c0 = ch;
          @(negedge clk);
          v0 = 1'b0;
        end
      join
      a_rx = rx0; a_ur = ur_cnt0;
      run_frame(FW1);
      b_rx = rx0; b_ur = ur_cnt0;
      led_m0 = 1'b1; led_m1 = 1'b1;
      tests_run += 3;
      if (a_ur + b_ur != 1) begin
        failures++; $display("FAIL simul_underruns k=%0d got %0d exp 1", k, a_ur + b_ur);
      end
      if (!((a_rx === e_full && b_rx === 64'd0) || (a_rx === 64'd0 && b_rx === e_full))) begin
        failures++; $display("FAIL simul_retained k=%0d got %h/%h exp %h once", k, a_rx, b_rx, e_full);
      end
      if (lvl0 !== 4'd0) begin failures++; $display("FAIL simul_level k=%0d got %0d exp 0", k, lvl0); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++) push(0, 24'($urandom), 2'($urandom));
      for (int i = 0; i < n1; i++) push(1, 24'($urandom), 2'($urandom));
      frame_and_check("random", $urandom_range(3, 30));
    end
    while (q0.size() > 0 || q1.size() > 0) frame_and_check("random_drain", FW1);
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) begin
      push(0, 24'($urandom), 2'($urandom));
      push(1, 24'($urandom), 2'($urandom));
    end
    @(negedge clk);
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    sck_bits(5);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run += 3;
    if ({sdo0, sdo1} !== 2'b00) begin failures++; $display("FAIL midreset_sdo got %b exp 00", {sdo0, sdo1}); end
    if ({lvl0, lvl1} !== 8'h00) begin failures++; $display("FAIL midreset_level got %h exp 00", {lvl0, lvl1}); end
    if ({led0, led1} !== 2'b00) begin failures++; $display("FAIL midreset_led got %b exp 00", {led0, led1}); end
    sck = 1'b0; cs_n = 1'b1;
    q0.delete(); q1.delete();
    led_m0 = 1'b0; led_m1 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    frame_and_check("midreset_next_underruns", FW1);
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_overflow();
    test_underrun();
    test_abort();
    test_push_at_frame_start();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/spi_stream_tx.md
SPI_STREAM_TX -- requirements
Module: spi_stream_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries; power of two, 2 minimum.
REQ-003 SHALL have parameter NUM_CH, default 2, number of audio channels; CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have parameter CPHA, default 0, SPI phase (CPOL fixed 0); 0 = sample on rising/shift on falling, 1 = shift on rising/sample on falling.
REQ-005 SHALL have port clk  input  1  system clock, at least 8x sck frequency.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port sck  input  1  SPI clock from MCU, asynchronous to clk.
REQ-008 SHALL have port cs_n  input  1  SPI chip select from MCU, active low, asynchronous.
REQ-009 SHALL have port sdo  output  1  SPI serial data to MCU.
REQ-010 SHALL have port sample_valid  input  1  producer sample strobe.
REQ-011 SHALL have port sample_ready  output  1  FIFO can accept.
REQ-012 SHALL have port sample_data  input  DATA_W  PCM sample.
REQ-013 SHALL have port sample_chan  input  CH_W  channel tag.
REQ-014 SHALL have port fifo_level  output  clog2(FIFO_DEPTH+1)  occupied entries.
REQ-015 SHALL have port underrun  output  1  one-cycle pulse, frame started with FIFO empty.
REQ-016 SHALL have port led  output  1  sticky underrun indicator.

Function
REQ-017 SHALL synchronise sck and cs_n through 2-FF synchronisers into clk; edges are detected on the synchronised copies only.
REQ-018 SHALL push {sample_chan, sample_data} when sample_valid && sample_ready; sample_ready = !full; fifo_level updates one cycle after push.
REQ-019 Frame SHALL be FRAME_W = 1 + CH_W + DATA_W bits, MSB first: {present, chan, data}.
REQ-020 On synchronised cs_n falling edge, SHALL pop the FIFO head into the shift register with present=1; if empty, SHALL load all zeros and pulse underrun.
REQ-021 Push and pop in the same cycle SHALL leave fifo_level unchanged; push while empty with simultaneous frame start SHALL yield underrun and the pushed sample retained.
REQ-022 CPHA=0: sdo SHALL present frame MSB within 2 clk of load; shift left on each synchronised sck falling edge.
REQ-023 CPHA=1: on each synchronised sck rising edge, sdo SHALL take shift-register MSB then shift left.
REQ-024 State machine SHALL be IDLE -> LOAD (one cycle) -> SHIFT -> IDLE; SHIFT exits on cs_n rising or after FRAME_W shifts (then DONE, holding sdo=0 until cs_n rises).
REQ-025 cs_n rising mid-frame SHALL abort to IDLE; the popped sample is discarded, no retransmission.
REQ-026 sdo SHALL be 0 whenever not in SHIFT; extra sck edges beyond FRAME_W SHALL shift out 0.
REQ-027 led SHALL set on any underrun pulse and stay set until reset.

Reset
REQ-028 Asserted reset_n SHALL immediately force: FSM IDLE, FIFO empty, fifo_level 0, sdo 0, underrun 0, led 0, synchronisers to idle levels (sck 0, cs_n 1); sample_ready 1 from first clk after release.
REQ-029 Reset mid-frame SHALL discard the frame and FIFO contents; no partial bits after release.

Structure
REQ-030 Package spi_stream_pkg SHALL hold the FSM state enum and frame-layout localparam helpers (CH_W, FRAME_W).
REQ-031 FIFO SHALL be sub-module sample_fifo (parametrised width/depth, level output, wrap-around pointers with extra MSB).

Verification
REQ-032 Default params, push 16'h1010 chan 1, one 18-bit CPHA=0 frame -> MCU reads 18'b1_1_0001000000010000, underrun 0.
REQ-033 Push 9 samples into depth 8 -> 9th held off, sample_ready 0, fifo_level 8; after one frame level 8 again once 9th accepted.
REQ-034 Frame with empty FIFO -> 18 zero bits read, underrun one pulse, led stays 1.
REQ-035 cs_n rises after 5 bits with 2 queued -> next frame carries second sample, fifo_level 0 after it.
REQ-036 CPHA=1, DATA_W=24, NUM_CH=4, push 24'hABCDEF chan 3 -> MCU reads 1_11_ABCDEF on falling edges.
REQ-037 reset_n low mid-frame with 3 queued -> sdo 0, fifo_level 0 immediately; next frame underruns.
